// File: rtl/tmr_irq_arbiter.sv
// Timer event collector and round-robin interrupt arbiter with irq/irq_ack handshake.
// Optional sticky overrun flags (ovr_o) are built when TMR_IRQ_OVERRUN_EN is defined.
module tmr_irq_arbiter #(
  parameter  int NUM_TMR = 4,
  localparam int NUM_SRC = 3 * NUM_TMR,
  localparam int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_SRC-1:0] evt_i,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic [NUM_SRC-1:0] sw_clr,
  input  logic               irq_ack,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pend_o
`ifdef TMR_IRQ_OVERRUN_EN
  ,
  output logic [NUM_SRC-1:0] ovr_o
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t             state_q;
  logic               irq_q;
  logic [ID_W-1:0]    irq_id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [NUM_SRC-1:0] evt_d_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] set, clr, ack_mask, elig;
  logic               ack_fire;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  int                 idx;

  assign set      = evt_i & ~evt_d_q & src_en;
  assign ack_fire = (state_q == BUSY) && irq_ack;

  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_mask[i] = ack_fire && (int'(irq_id_q) == i);
    end
  end

  assign clr    = sw_clr | ack_mask;
  assign pend_d = set | (pend_q & ~clr);
  assign elig   = pend_q & src_en;

  // Walk from the farthest offset down so the nearest eligible index at/after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (elig[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      evt_d_q <= '0;
      pend_q  <= '0;
    end else begin
      evt_d_q <= evt_i;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            irq_id_q <= grant_id;
            irq_q    <= 1'b1;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (ack_fire) begin
            rr_ptr_q <= (irq_id_q == ID_W'(NUM_SRC - 1)) ? '0 : irq_id_q + 1'b1;
            irq_q    <= 1'b0;
            state_q  <= GAP;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;
  assign pend_o = pend_q;

`ifdef TMR_IRQ_OVERRUN_EN
  logic [NUM_SRC-1:0] ovr_q;

  // Overrun: an edge lands on a source that is already pending and not being cleared.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= (set & pend_q & ~clr) | (ovr_q & ~sw_clr);
    end
  end

  assign ovr_o = ovr_q;
`endif

endmodule

// File: tb/tb_tmr_irq_arbiter.sv
// Self-checking bench for tmr_irq_arbiter (NUM_TMR=4): vector table plus scoreboarded grant sequences.
// Overrun checks are compiled in when TMR_IRQ_OVERRUN_EN is defined.
module tb_tmr_irq_arbiter;

  localparam int NUM_SRC = 12;
  localparam int ID_W    = 4;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n;
  logic [NUM_SRC-1:0] evt_i, src_en, sw_clr;
  logic               irq_ack;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] pend_o;
`ifdef TMR_IRQ_OVERRUN_EN
  logic [NUM_SRC-1:0] ovr_o;
`endif

  tmr_irq_arbiter #(.NUM_TMR(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .evt_i     (evt_i),
    .src_en    (src_en),
    .sw_clr    (sw_clr),
    .irq_ack   (irq_ack),
    .irq       (irq),
    .irq_id    (irq_id),
    .pend_o    (pend_o)
`ifdef TMR_IRQ_OVERRUN_EN
    ,
    .ovr_o     (ovr_o)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [NUM_SRC-1:0] en;
    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] exp_pend;
    logic               exp_irq;
    logic [ID_W-1:0]    exp_id;
  } vec_t;

  vec_t vecs[5];
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    evt_i = '0; src_en = '0; sw_clr = '0; irq_ack = 1'b0;
    cyc(); cyc();
    sys_rst_n = 1'b1;
    cyc();
  endtask

  task automatic wait_irq(input int limit, output int waited);
    waited = 0;
    while (!irq && waited < limit) begin
      cyc();
      waited++;
    end
    if (!irq) chk("irq_timeout", {31'd0, irq}, 32'd1);
  endtask

  // Wait for a request, compare against the scoreboard head, acknowledge for one cycle.
  task automatic serve(input string nm, output int waited);
    int exp_id;
    wait_irq(10, waited);
    if (irq) begin
      if (exp_q.size() == 0) begin
        chk({nm, "_unexpected"}, {28'd0, irq_id}, 32'hFFFF);
      end else begin
        exp_id = exp_q.pop_front();
        chk(nm, {28'd0, irq_id}, exp_id);
      end
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      chk({nm, "_drop"}, {31'd0, irq}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    vecs[0] = '{12'hFFF, 12'h020, 12'h020, 1'b1, 4'd5};
    vecs[1] = '{12'hFFD, 12'h002, 12'h000, 1'b0, 4'd0};
    vecs[2] = '{12'h0F0, 12'h8F1, 12'h0F0, 1'b1, 4'd4};
    vecs[3] = '{12'hFFF, 12'hC00, 12'hC00, 1'b1, 4'd10};
    vecs[4] = '{12'h800, 12'hFFF, 12'h800, 1'b1, 4'd11};

    // T1: reset with all events high; a held level after release is not an edge
    sys_rst_n = 1'b0;
    evt_i = '1; src_en = '0; sw_clr = '0; irq_ack = 1'b0;
    cyc(); cyc();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_id", {28'd0, irq_id}, 32'd0);
    chk("rst_pend", {20'd0, pend_o}, 32'd0);
    sys_rst_n = 1'b1;
    cyc(); cyc();
    src_en = '1;
    cyc(); cyc(); cyc();
    chk("held_level_pend", {20'd0, pend_o}, 32'd0);
    chk("held_level_irq", {31'd0, irq}, 32'd0);

    // Vector table: single-cycle event pattern, pend after one edge, grant after two
    for (int v = 0; v < 5; v++) begin
      do_reset();
      src_en = vecs[v].en;
      evt_i  = vecs[v].evt;
      cyc();
      evt_i = '0;
      chk($sformatf("vec%0d_pend", v), {20'd0, pend_o}, {20'd0, vecs[v].exp_pend});
      cyc();
      chk($sformatf("vec%0d_irq", v), {31'd0, irq}, {31'd0, vecs[v].exp_irq});
      chk($sformatf("vec%0d_id", v), {28'd0, irq_id}, {28'd0, vecs[v].exp_id});
    end

    // T2: single held event, latency and one-shot behaviour
    do_reset();
    src_en = '1;
    evt_i  = 12'h020;
    cyc();
    chk("t2_pend_k1", {20'd0, pend_o}, 32'h020);
    chk("t2_irq_k1", {31'd0, irq}, 32'd0);
    cyc();
    chk("t2_irq_k2", {31'd0, irq}, 32'd1);
    chk("t2_id_k2", {28'd0, irq_id}, 32'd5);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_irq_hold", {31'd0, irq}, 32'd1);
      chk("t2_id_hold", {28'd0, irq_id}, 32'd5);
    end
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    chk("t2_irq_ack", {31'd0, irq}, 32'd0);
    chk("t2_pend_ack", {20'd0, pend_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_no_rereq", {31'd0, irq}, 32'd0);
    end
    evt_i = '0;

    // T3: all sources pending, served in index order, then wrap
    do_reset();
    src_en = '1;
    evt_i  = '1;
    for (int i = 0; i < NUM_SRC; i++) exp_q.push_back(i);
    cyc();
    evt_i = '0;
    chk("t3_pend_all", {20'd0, pend_o}, 32'hFFF);
    for (int i = 0; i < NUM_SRC; i++) begin
      serve($sformatf("t3_rr%0d", i), w);
      if (i > 0) chk("t3_gap", w, 32'd2);
    end
    chk("t3_pend_empty", {20'd0, pend_o}, 32'd0);
    evt_i = 12'h009;
    exp_q.push_back(0);
    exp_q.push_back(3);
    cyc();
    evt_i = '0;
    serve("t3_wrap0", w);
    serve("t3_wrap3", w);

    // T4: set beats clear; clear/disable during BUSY does not withdraw irq; ack collision
    do_reset();
    src_en = '1;
    evt_i  = 12'h004;
    cyc();
    evt_i = '0;
    cyc();
    chk("t4_irq2", {31'd0, irq}, 32'd1);
    chk("t4_id2", {28'd0, irq_id}, 32'd2);
    evt_i  = 12'h004;
    sw_clr = 12'h004;
    cyc();
    evt_i  = '0;
    sw_clr = '0;
    chk("t4_set_wins", {20'd0, pend_o}, 32'h004);
    sw_clr = 12'h004;
    src_en = 12'hFFB;
    cyc();
    sw_clr = '0;
    chk("t4_swclr_pend", {20'd0, pend_o}, 32'd0);
    chk("t4_busy_irq", {31'd0, irq}, 32'd1);
    chk("t4_busy_id", {28'd0, irq_id}, 32'd2);
    src_en = '1;
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    chk("t4_ack2", {31'd0, irq}, 32'd0);
    evt_i = 12'h080;
    exp_q.push_back(7);
    cyc();
    evt_i = '0;
    wait_irq(10, w);
    chk("t4_id7", {28'd0, irq_id}, exp_q.pop_front());
    irq_ack = 1'b1;
    evt_i   = 12'h080;
    cyc();
    irq_ack = 1'b0;
    evt_i   = '0;
    chk("t4_ack_edge_pend", {20'd0, pend_o}, 32'h080);
    chk("t4_ack_edge_irq", {31'd0, irq}, 32'd0);
    exp_q.push_back(7);
    serve("t4_reserve7", w);
    chk("t4_pend_final", {20'd0, pend_o}, 32'd0);

    // T5: pending but disabled source is held; async reset mid-request
    do_reset();
    src_en = '1;
    evt_i  = 12'h002;
    cyc();
    evt_i  = '0;
    src_en = 12'hFFD;
    cyc(); cyc(); cyc();
    chk("t5_held_pend", {20'd0, pend_o}, 32'h002);
    chk("t5_held_irq", {31'd0, irq}, 32'd0);
    src_en = '1;
    exp_q.push_back(1);
    serve("t5_reenabled", w);
    evt_i = 12'h001;
    cyc();
    evt_i = '0;
    cyc();
    chk("t5_pre_rst_irq", {31'd0, irq}, 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t5_async_irq", {31'd0, irq}, 32'd0);
    chk("t5_async_pend", {20'd0, pend_o}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    cyc(); cyc();
    chk("t5_lost_irq", {31'd0, irq}, 32'd0);
    evt_i = 12'h010;
    exp_q.push_back(4);
    cyc();
    evt_i = '0;
    serve("t5_after_rst", w);

`ifdef TMR_IRQ_OVERRUN_EN
    // T6: second edge while pending sets overrun; sw_clr clears both
    do_reset();
    src_en = '1;
    evt_i  = 12'h010;
    cyc();
    evt_i = '0;
    cyc();
    chk("t6_ovr_none", {20'd0, ovr_o}, 32'd0);
    evt_i = 12'h010;
    cyc();
    evt_i = '0;
    chk("t6_ovr_set", {20'd0, ovr_o}, 32'h010);
    sw_clr = 12'h010;
    cyc();
    sw_clr = '0;
    chk("t6_ovr_clr", {20'd0, ovr_o}, 32'd0);
    chk("t6_pend_clr", {20'd0, pend_o}, 32'd0);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
`endif

    if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
